apple_spawner: RTL and testbench

Places the apple on the snake playfield. It reads the WIDTH×HEIGHT occupancy bitmap that the snake body tracker produces, where a 1 means occupied. On each spawn request it picks a pseudo-random free cell and presents it as the new apple coordinate. It sits between the body tracker and the collision/eat logic, which issues the spawn request when the head lands on the apple.

---
 rtl/snake_pkg.sv | 19 +
 rtl/lfsr16.sv | 33 +++
 rtl/apple_spawner.sv | 170 +++++++++++++++++
 tb/tb_apple_spawner.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: definitions shared by the snake playfield blocks.
//   coord_t          7-bit playfield coordinate, the width used on all ports
//   spawn_state_t    state encoding of the apple spawner search FSM
//   LFSR_TAPS        feedback mask of the 16-bit Fibonacci LFSR (taps 16,14,13,11)
package snake_pkg;

    typedef logic [6:0] coord_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PROBE,
        ST_FULL
    } spawn_state_t;

    // Taps 16,14,13,11 map to bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR.
//   clk    clock
//   reset  synchronous, active-low; loads SEED
//   out    current LFSR state, advances on every clock edge out of reset
module lfsr16
    import snake_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] out
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Shift towards the MSB, feeding the XOR of the tapped bits into bit 0.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out = lfsr_q;

endmodule

// File: rtl/apple_spawner.sv
// apple_spawner: places the apple on a free playfield cell.
//   clk, reset      clock; synchronous active-low reset
//   spawn_req       one-cycle request for a new apple (ignored while busy / full)
//   dead            game over; aborts any running search
//   body            occupancy bitmap body[x][y], 1 = occupied
//   snakeX/snakeY   head coordinate, treated as occupied (body lags by a cycle)
//   appleX/appleY   registered apple coordinate
//   busy            search in progress (includes the spawn_done cycle)
//   spawn_done      one-cycle pulse when appleX/appleY hold the new apple
//   full            sticky: a full sweep found no free cell
// The search starts at an LFSR-derived cell and walks y-major (y first, then
// x) one cell per cycle, sampling body and head live on every probe.
module apple_spawner
    import snake_pkg::*;
#(
    parameter int          WIDTH    = 32,
    parameter int          HEIGHT   = 32,
    parameter int          START_AX = 10,
    parameter int          START_AY = 10,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           spawn_req,
    input  logic                           dead,
    input  logic [WIDTH-1:0][HEIGHT-1:0]   body,
    input  coord_t                         snakeX,
    input  coord_t                         snakeY,
    output coord_t                         appleX,
    output coord_t                         appleY,
    output logic                           busy,
    output logic                           spawn_done,
    output logic                           full
);

    localparam int XB    = $clog2(WIDTH);
    localparam int YB    = $clog2(HEIGHT);
    localparam int CELLS = WIDTH * HEIGHT;
    // One extra bit so the probe count can represent a full sweep.
    localparam int CW    = XB + YB + 1;

    localparam logic [YB-1:0] Y_LAST   = YB'(HEIGHT - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CELLS - 1);

    logic [15:0]   lfsr_val;
    logic          unused_lfsr_bits;

    spawn_state_t  state_q, state_d;
    logic [XB-1:0] cand_x_q, cand_x_d;
    logic [YB-1:0] cand_y_q, cand_y_d;
    logic [CW-1:0] probe_cnt_q, probe_cnt_d;
    coord_t        apple_x_q, apple_x_d;
    coord_t        apple_y_q, apple_y_d;
    logic          busy_q, busy_d;
    logic          spawn_done_q, spawn_done_d;
    logic          full_q, full_d;
    logic          cell_occupied;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .out   (lfsr_val)
    );

    // Only the low XB+YB bits seed the candidate.
    assign unused_lfsr_bits = ^lfsr_val[15:XB+YB];

    // The head counts as occupied because body has not caught up with it yet.
    assign cell_occupied = body[cand_x_q][cand_y_q]
                         | ((snakeX == coord_t'(cand_x_q)) && (snakeY == coord_t'(cand_y_q)));

    always_comb begin
        state_d      = state_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        probe_cnt_d  = probe_cnt_q;
        apple_x_d    = apple_x_q;
        apple_y_d    = apple_y_q;
        busy_d       = busy_q;
        spawn_done_d = 1'b0;
        full_d       = full_q;

        if (dead && (state_q != ST_FULL)) begin
            // Abort: apple untouched, no completion pulse.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // busy_q can still be high here during the spawn_done
                    // cycle; a request then is dropped like any other busy one.
                    if (spawn_req && !busy_q) begin
                        state_d = ST_LOAD;
                        busy_d  = 1'b1;
                    end else begin
                        busy_d  = 1'b0;
                    end
                end
                ST_LOAD: begin
                    cand_x_d    = lfsr_val[XB-1:0];
                    cand_y_d    = lfsr_val[XB+YB-1:XB];
                    probe_cnt_d = '0;
                    state_d     = ST_PROBE;
                end
                ST_PROBE: begin
                    if (!cell_occupied) begin
                        apple_x_d    = coord_t'(cand_x_q);
                        apple_y_d    = coord_t'(cand_y_q);
                        spawn_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        if (cand_y_q == Y_LAST) begin
                            cand_y_d = '0;
                            cand_x_d = cand_x_q + XB'(1);  // wraps at WIDTH
                        end else begin
                            cand_y_d = cand_y_q + YB'(1);
                        end
                        probe_cnt_d = probe_cnt_q + CW'(1);
                        if (probe_cnt_q == CNT_LAST) begin
                            state_d = ST_FULL;
                            full_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end
                end
                ST_FULL: begin
                    busy_d = 1'b0;
                    full_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            probe_cnt_q  <= '0;
            apple_x_q    <= coord_t'(START_AX);
            apple_y_q    <= coord_t'(START_AY);
            busy_q       <= 1'b0;
            spawn_done_q <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            probe_cnt_q  <= probe_cnt_d;
            apple_x_q    <= apple_x_d;
            apple_y_q    <= apple_y_d;
            busy_q       <= busy_d;
            spawn_done_q <= spawn_done_d;
            full_q       <= full_d;
        end
    end

    assign appleX     = apple_x_q;
    assign appleY     = apple_y_q;
    assign busy       = busy_q;
    assign spawn_done = spawn_done_q;
    assign full       = full_q;

endmodule

// File: tb/tb_apple_spawner.sv
// Testbench for apple_spawner: randomized spawns with live body changes,
// checked every cycle against a cell-index model of the search, plus
// directed boundary cases with literal expectations.
module tb_apple_spawner;

    localparam int          W    = 32;
    localparam int          H    = 32;
    localparam int          N    = W * H;
    localparam logic [15:0] SEED = 16'hACE1;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_PROBE = 2;
    localparam int M_FULL  = 3;

    logic                 clk;
    logic                 reset;
    logic                 spawn_req;
    logic                 dead;
    logic [W-1:0][H-1:0]  body;
    logic [6:0]           snakeX;
    logic [6:0]           snakeY;
    logic [6:0]           appleX;
    logic [6:0]           appleY;
    logic                 busy;
    logic                 spawn_done;
    logic                 full;

    int checks   = 0;
    int failures = 0;

    apple_spawner #(
        .WIDTH    (W),
        .HEIGHT   (H),
        .START_AX (10),
        .START_AY (10),
        .SEED     (SEED)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .spawn_req  (spawn_req),
        .dead       (dead),
        .body       (body),
        .snakeX     (snakeX),
        .snakeY     (snakeY),
        .appleX     (appleX),
        .appleY     (appleY),
        .busy       (busy),
        .spawn_done (spawn_done),
        .full       (full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // ---------------- behavioural model ----------------
    // The search is modelled as a walk over the linear cell index x*H+y,
    // which is exactly the y-then-x probe order with wrap-around.
    logic [15:0] m_lfsr;
    logic [15:0] m_cur;
    int          m_mode;
    int          m_start;
    int          m_k;
    int          m_lin, m_px, m_py;
    int          exp_ax, exp_ay;
    logic        exp_busy, exp_done, exp_full;
    int          n_spawns = 0;

    always @(posedge clk) begin
        if (!reset) begin
            m_lfsr   = SEED;
            m_mode   = M_IDLE;
            exp_ax   = 10;
            exp_ay   = 10;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_full = 1'b0;
        end else begin
            m_cur    = m_lfsr;
            exp_done = 1'b0;
            if (dead && m_mode != M_FULL) begin
                m_mode   = M_IDLE;
                exp_busy = 1'b0;
            end else begin
                case (m_mode)
                    M_IDLE: begin
                        if (spawn_req && !exp_busy) begin
                            m_mode   = M_LOAD;
                            exp_busy = 1'b1;
                        end else begin
                            exp_busy = 1'b0;
                        end
                    end
                    M_LOAD: begin
                        m_start = int'(m_cur % W) * H + int'((m_cur / W) % H);
                        m_k     = 0;
                        m_mode  = M_PROBE;
                    end
                    M_PROBE: begin
                        m_lin = (m_start + m_k) % N;
                        m_px  = m_lin / H;
                        m_py  = m_lin % H;
                        if (body[m_px][m_py] == 1'b0 &&
                            !(int'(snakeX) == m_px && int'(snakeY) == m_py)) begin
                            exp_ax   = m_px;
                            exp_ay   = m_py;
                            exp_done = 1'b1;
                            m_mode   = M_IDLE;
                        end else begin
                            m_k++;
                            if (m_k == N) begin
                                m_mode   = M_FULL;
                                exp_full = 1'b1;
                                exp_busy = 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            m_lfsr = lfsr_next(m_cur);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("appleX", 32'(appleX), 32'(exp_ax));
        chk("appleY", 32'(appleY), 32'(exp_ay));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("spawn_done", 32'(spawn_done), 32'(exp_done));
        chk("full", 32'(full), 32'(exp_full));
        if (exp_done) begin
            n_spawns++;
            $display("spawn %0d: apple=(%0d,%0d) dut=(%0d,%0d) t=%0t",
                     n_spawns, exp_ax, exp_ay, appleX, appleY, $time);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Caller is just after a posedge; request is driven for one cycle and
    // lat is the number of cycles until spawn_done is seen (-1 if never).
    task automatic spawn_and_wait(input int budget, output int lat);
        spawn_req = 1'b1;
        lat = -1;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk); #2 spawn_req = 1'b0;
            @(negedge clk);
            if (spawn_done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_timeout", 32'(ok), 32'd1);
    endtask

    task automatic rand_body();
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                body[x][y] = ($urandom_range(0, 3) == 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int done_cnt;
        logic found;
        logic [15:0] nx;

        reset = 1'b0; spawn_req = 1'b0; dead = 1'b0;
        body = '0; snakeX = 7'd100; snakeY = 7'd100;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("rst_lfsr", 32'(dut.lfsr_val), 32'h0000ACE1);
        chk("rst_appleX", 32'(appleX), 32'd10);
        chk("rst_appleY", 32'(appleY), 32'd10);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_full", 32'(full), 32'd0);

        // Empty body: minimum latency, apple from the LOAD-cycle LFSR value.
        @(posedge clk); #2;
        nx = lfsr_next(m_lfsr);
        spawn_and_wait(10, lat);
        chk("empty_latency", 32'(lat), 32'd3);
        chk("empty_appleX", 32'(appleX), 32'(nx[4:0]));
        chk("empty_appleY", 32'(appleY), 32'(nx[9:5]));
        wait_idle(5);

        // Randomized spawns, with live body flips and ignored requests.
        for (int it = 0; it < 40; it++) begin
            rand_body();
            snakeX = 7'($urandom_range(0, W - 1));
            snakeY = 7'($urandom_range(0, H - 1));
            @(posedge clk); #2;
            spawn_req = 1'b1;
            dead = ($urandom_range(0, 7) == 0);
            found = 1'b0;
            for (int n = 0; n < 1200; n++) begin
                @(posedge clk); #2;
                dead = 1'b0;
                spawn_req = busy && ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 3) == 0)
                    body[$urandom_range(0, W - 1)][$urandom_range(0, H - 1)] ^= 1'b1;
                @(negedge clk);
                if (!busy) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("rand_idle", 32'(found), 32'd1);
        end

        // Candidate (3,31) occupied: y wraps, x increments -> (4,0).
        body = '0; body[3][31] = 1'b1; snakeX = 7'd100; snakeY = 7'd100;
        found = 1'b0;
        for (int n = 0; n < 70000; n++) begin
            @(posedge clk); #2;
            nx = lfsr_next(m_lfsr);
            if (nx[4:0] == 5'd3 && nx[9:5] == 5'd31) begin
                found = 1'b1;
                break;
            end
        end
        chk("force_found", 32'(found), 32'd1);
        spawn_and_wait(10, lat);
        chk("wrap_latency", 32'(lat), 32'd4);
        chk("wrap_appleX", 32'(appleX), 32'd4);
        chk("wrap_appleY", 32'(appleY), 32'd0);
        wait_idle(5);

        // Head on the only reachable free cell (2,5): skipped, (2,6) chosen.
        body = '1; body[2][5] = 1'b0; body[2][6] = 1'b0;
        snakeX = 7'd2; snakeY = 7'd5;
        @(posedge clk); #2;
        spawn_and_wait(1100, lat);
        chk("skip_done", 32'(lat > 0), 32'd1);
        chk("skip_appleX", 32'(appleX), 32'd2);
        chk("skip_appleY", 32'(appleY), 32'd6);
        wait_idle(5);

        // dead mid-PROBE aborts without a pulse and keeps the apple.
        body = '1; snakeX = 7'd100; snakeY = 7'd100;
        @(posedge clk); #2 spawn_req = 1'b1;
        @(posedge clk); #2 spawn_req = 1'b0;
        repeat (6) @(posedge clk);
        #2 dead = 1'b1;
        @(posedge clk); #2 dead = 1'b0;
        @(negedge clk);
        chk("dead_busy", 32'(busy), 32'd0);
        done_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (spawn_done) done_cnt++;
        end
        chk("dead_nodone", 32'(done_cnt), 32'd0);
        chk("dead_appleX", 32'(appleX), 32'd2);
        chk("dead_appleY", 32'(appleY), 32'd6);

        // Reset mid-search restores reset values.
        @(posedge clk); #2 spawn_req = 1'b1;
        @(posedge clk); #2 spawn_req = 1'b0;
        repeat (6) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk); #2 reset = 1'b1;
        @(negedge clk);
        chk("rst2_lfsr", 32'(dut.lfsr_val), 32'h0000ACE1);
        chk("rst2_appleX", 32'(appleX), 32'd10);
        chk("rst2_appleY", 32'(appleY), 32'd10);
        chk("rst2_busy", 32'(busy), 32'd0);

        // Only (0,0) free: found within the maximum latency.
        body = '1; body[0][0] = 1'b0;
        @(posedge clk); #2;
        spawn_and_wait(1100, lat);
        chk("last_found", 32'(lat > 0 && lat <= 2 + N), 32'd1);
        chk("last_appleX", 32'(appleX), 32'd0);
        chk("last_appleY", 32'(appleY), 32'd0);
        wait_idle(5);

        // No free cell: full sweep ends in FULL, later requests ignored.
        body = '1;
        @(posedge clk); #2;
        spawn_and_wait(1100, lat);
        chk("full_nodone", 32'(lat), 32'hFFFFFFFF);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_busy", 32'(busy), 32'd0);
        body = '0;
        @(posedge clk); #2;
        spawn_and_wait(40, lat);
        chk("full_ignore", 32'(lat), 32'hFFFFFFFF);
        chk("full_sticky", 32'(full), 32'd1);

        // Reset leaves FULL.
        @(posedge clk); #2 reset = 1'b0;
        @(posedge clk); #2 reset = 1'b1;
        @(negedge clk);
        chk("rst3_full", 32'(full), 32'd0);
        chk("rst3_appleX", 32'(appleX), 32'd10);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
